// File: rtl/thread_sched.sv
// thread_sched: per-thread FREE/RUN/SLEEP context tracking, init allocation and round-robin fetch select.
// Optional SLEEP_TIMEOUT_EN adds per-thread 8-bit sleep counters that auto-wake a thread on reaching 255.
module thread_sched #(
   parameter int NUM_THREAD = 8,
   parameter int TID_W      = $clog2(NUM_THREAD)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   input  logic [1:0]            trd_ctrl,
   input  logic [TID_W-1:0]      ctrl_tid,
   input  logic [TID_W-1:0]      target_tid,
   input  logic                  init_req,
   output logic                  init_gnt,
   output logic [TID_W-1:0]      init_tid,
   output logic                  init_fail,
   input  logic                  stall,
   output logic                  fetch_valid,
   output logic [TID_W-1:0]      fetch_tid,
   output logic [NUM_THREAD-1:0] run_mask
);

   typedef enum logic [1:0] {
      ST_FREE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_SLEEP = 2'b10
   } tstate_e;

   tstate_e                 state_q [NUM_THREAD];
   tstate_e                 state_d [NUM_THREAD];
`ifdef SLEEP_TIMEOUT_EN
   logic [7:0]              cnt_q   [NUM_THREAD];
   logic [7:0]              cnt_d   [NUM_THREAD];
`endif
   logic                    init_gnt_q, init_gnt_d;
   logic [TID_W-1:0]        init_tid_q, init_tid_d;
   logic                    init_fail_q, init_fail_d;
   logic                    fetch_valid_q, fetch_valid_d;
   logic [TID_W-1:0]        fetch_tid_q, fetch_tid_d;
   logic [NUM_THREAD-1:0]   run_mask_q, run_mask_d;

   logic                    do_sleep, do_wake, do_kill;
   logic                    alloc_found;
   logic [TID_W-1:0]        alloc_tid;
   logic                    sel_found;
   logic [TID_W-1:0]        sel_tid;
   logic [TID_W-1:0]        idx;

   always_comb begin
      do_sleep    = ctrl_valid && (trd_ctrl == 2'b01);
      do_wake     = ctrl_valid && (trd_ctrl == 2'b10);
      do_kill     = ctrl_valid && (trd_ctrl == 2'b11);
      alloc_found = 1'b0;
      alloc_tid   = '0;
      sel_found   = 1'b0;
      sel_tid     = fetch_tid_q;
      idx         = '0;
      run_mask_d  = '0;

      // Allocation sees only pre-edge state; a kill target is never handed out the same cycle.
      for (int i = NUM_THREAD - 1; i >= 0; i--) begin
         if ((state_q[i] == ST_FREE) && !(do_kill && (target_tid == TID_W'(i)))) begin
            alloc_found = 1'b1;
            alloc_tid   = TID_W'(i);
         end
      end

      for (int i = 0; i < NUM_THREAD; i++) begin
         state_d[i] = state_q[i];
`ifdef SLEEP_TIMEOUT_EN
         cnt_d[i] = (state_q[i] == ST_SLEEP) ? (cnt_q[i] + 8'd1) : 8'd0;
         if ((state_q[i] == ST_SLEEP) && (cnt_q[i] == 8'hFF)) begin
            state_d[i] = ST_RUN;
         end
`endif
         if (do_sleep && (ctrl_tid == TID_W'(i)) && (state_q[i] == ST_RUN)) begin
            state_d[i] = ST_SLEEP;
         end
         if (do_wake && (target_tid == TID_W'(i)) && (state_q[i] == ST_SLEEP)) begin
            state_d[i] = ST_RUN;
         end
         if (init_req && alloc_found && (alloc_tid == TID_W'(i))) begin
            state_d[i] = ST_RUN;
         end
         if (do_kill && (target_tid == TID_W'(i))) begin
            state_d[i] = ST_FREE;
         end
         run_mask_d[i] = (state_d[i] == ST_RUN);
      end

      // Scan starts just after the last fetched thread; the last step revisits it so a lone runner repeats.
      for (int k = 1; k <= NUM_THREAD; k++) begin
         idx = fetch_tid_q + TID_W'(k);
         if (!sel_found && run_mask_d[idx]) begin
            sel_found = 1'b1;
            sel_tid   = idx;
         end
      end

      if (stall) begin
         fetch_valid_d = fetch_valid_q;
         fetch_tid_d   = fetch_tid_q;
      end else begin
         fetch_valid_d = sel_found;
         fetch_tid_d   = sel_tid;
      end

      init_gnt_d  = init_req && alloc_found;
      init_fail_d = init_req && !alloc_found;
      init_tid_d  = (init_req && alloc_found) ? alloc_tid : init_tid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_THREAD; i++) begin
            state_q[i] <= (i == 0) ? ST_RUN : ST_FREE;
`ifdef SLEEP_TIMEOUT_EN
            cnt_q[i]   <= 8'd0;
`endif
         end
         init_gnt_q    <= 1'b0;
         init_tid_q    <= '0;
         init_fail_q   <= 1'b0;
         fetch_valid_q <= 1'b1;
         fetch_tid_q   <= '0;
         run_mask_q    <= NUM_THREAD'(1);
      end else begin
         for (int i = 0; i < NUM_THREAD; i++) begin
            state_q[i] <= state_d[i];
`ifdef SLEEP_TIMEOUT_EN
            cnt_q[i]   <= cnt_d[i];
`endif
         end
         init_gnt_q    <= init_gnt_d;
         init_tid_q    <= init_tid_d;
         init_fail_q   <= init_fail_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_tid_q   <= fetch_tid_d;
         run_mask_q    <= run_mask_d;
      end
   end

   assign init_gnt    = init_gnt_q;
   assign init_tid    = init_tid_q;
   assign init_fail   = init_fail_q;
   assign fetch_valid = fetch_valid_q;
   assign fetch_tid   = fetch_tid_q;
   assign run_mask    = run_mask_q;

endmodule
